// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
// Bundles the requester-side and RAM-side signals of ram_arbiter.
//   req/req_wr_rd/req_addr/req_din : per-requester access requests (sliced per requester)
//   gnt/rvalid/rdata/busy          : grant pulse, read-data-valid pulse, shared read data, busy flag
//   ram_en/ram_wr_rd/ram_addr/ram_din/ram_dout : single-port synchronous RAM port
// Modports: slave = the arbiter, master = requesters plus RAM model.
interface ram_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_wr_rd;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_din;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]         rdata;
    logic                          busy;
    logic                          ram_en;
    logic                          ram_wr_rd;
    logic [ADDR_WIDTH-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0]         ram_din;
    logic [DATA_WIDTH-1:0]         ram_dout;

    modport slave (
        input  req, req_wr_rd, req_addr, req_din, ram_dout,
        output gnt, rvalid, rdata, busy, ram_en, ram_wr_rd, ram_addr, ram_din
    );

    modport master (
        output req, req_wr_rd, req_addr, req_din, ram_dout,
        input  gnt, rvalid, rdata, busy, ram_en, ram_wr_rd, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Round-robin arbiter sharing one single-port synchronous RAM among NUM_REQ
// requesters. One winner is latched per arbitration, the RAM is driven for one
// cycle, and read data is returned to the winner with a one-cycle rvalid pulse.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : ram_arbiter_if.slave (requester handshake and RAM port)
//
// state | meaning
// IDLE  | arbitrate; latch winner and its op/addr/data when any req is set
// ISSUE | ram_en and gnt pulse for the latched access
// RDATA | RAM output valid; captured into rdata, rvalid pulses next cycle
module ram_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [IDX_W-1:0]       win_q, win_d;
    logic                   op_q, op_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  din_q, din_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   ram_en_q, ram_en_d;

    logic [IDX_W-1:0]       pick;
    logic                   found;

    // Search starts one past the last winner and wraps, so the last winner
    // is considered only when nobody else is requesting.
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && bus.req[(int'(last_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                pick  = IDX_W'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        op_d     = op_q;
        addr_d   = addr_q;
        din_d    = din_q;
        gnt_d    = '0;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        ram_en_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d       = pick;
                    last_d      = pick;
                    op_d        = bus.req_wr_rd[pick];
                    addr_d      = bus.req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
                    din_d       = bus.req_din[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                    gnt_d[pick] = 1'b1;
                    ram_en_d    = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = op_q ? IDLE : RDATA;
            end
            RDATA: begin
                rdata_d         = bus.ram_dout;
                rvalid_d[win_q] = 1'b1;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= IDX_W'(NUM_REQ - 1);
            win_q    <= '0;
            op_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            ram_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            ram_en_q <= ram_en_d;
        end
    end

    // The latch registers feed the RAM directly; they stay stale while ram_en is low.
    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_wr_rd = op_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_din   = din_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Self-checking bench for ram_arbiter: reset values, a table of round-robin
// arbitration vectors, hand-written multi-cycle sequences, and a randomized
// run checked against a transaction-level reference model.
module tb_ram_arbiter;
    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single-port synchronous RAM model: read data one cycle after enable.
    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] ram_dout_r = '0;
    bit            ram_clear  = 1'b1;
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= '0;
        end else if (bus.ram_en) begin
            if (bus.ram_wr_rd) ram_mem[bus.ram_addr] <= bus.ram_din;
            else               ram_dout_r <= ram_mem[bus.ram_addr];
        end
    end
    assign bus.ram_dout = ram_dout_r;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic on, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[i]               = on;
        bus.req_wr_rd[i]         = wr;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_din[i*DW +: DW]  = d;
    endtask

    // Returns at a negedge with rst just released; the next posedge is live.
    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] exp_gnt;
    } vec_t;
    vec_t tbl[10];

    typedef struct {
        int            at;
        int            idx;
        logic [DW-1:0] data;
    } rv_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int            got[$];
        int            ea;
        logic [N-1:0]  eg, er;
        // reference model state
        int            cyc, free_cyc, last_ref, gnt_at, g_idx;
        logic          g_wr;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_din;
        logic [DW-1:0] mem_ref [16];
        logic [DW-1:0] rdata_exp;
        rv_t           rvq[$];
        rv_t           r;

        // Round-robin vectors from reset (last = 3); each access is a write.
        tbl[0] = '{4'b1111, 4'b0001};
        tbl[1] = '{4'b1111, 4'b0010};
        tbl[2] = '{4'b1001, 4'b1000};
        tbl[3] = '{4'b1001, 4'b0001};
        tbl[4] = '{4'b0100, 4'b0100};
        tbl[5] = '{4'b0011, 4'b0001};
        tbl[6] = '{4'b1110, 4'b0010};
        tbl[7] = '{4'b1000, 4'b1000};
        tbl[8] = '{4'b1000, 4'b1000};
        tbl[9] = '{4'b0110, 4'b0010};

        bus.req       = '0;
        bus.req_wr_rd = '0;
        bus.req_addr  = '0;
        bus.req_din   = '0;

        // ---- Reset values, then first grant with all requesting ----
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, AW'(i + 8), DW'(16 * i + 1));
        repeat (2) @(negedge clk);
        ram_clear = 1'b0;
        check("rst_gnt",       32'(bus.gnt), 32'h0);
        check("rst_rvalid",    32'(bus.rvalid), 32'h0);
        check("rst_busy",      32'(bus.busy), 32'h0);
        check("rst_ram_en",    32'(bus.ram_en), 32'h0);
        check("rst_rdata",     32'(bus.rdata), 32'h0);
        check("rst_ram_addr",  32'(bus.ram_addr), 32'h0);
        check("rst_ram_din",   32'(bus.ram_din), 32'h0);
        check("rst_ram_wr_rd", 32'(bus.ram_wr_rd), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("first_gnt",      32'(bus.gnt), 32'h1);
        check("first_ram_en",   32'(bus.ram_en), 32'h1);
        check("first_ram_addr", 32'(bus.ram_addr), 32'h8);
        check("first_busy",     32'(bus.busy), 32'h1);
        bus.req = '0;

        // ---- Table-driven round-robin vectors ----
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b1, AW'(i + 4), DW'(8'h30 + i));
        for (int e = 0; e < 10; e++) begin
            bus.req = tbl[e].req;
            @(negedge clk);
            ea = 0;
            for (int j = 0; j < N; j++) if (tbl[e].exp_gnt[j]) ea = j + 4;
            check($sformatf("tbl%0d_gnt", e),      32'(bus.gnt), 32'(tbl[e].exp_gnt));
            check($sformatf("tbl%0d_ram_en", e),   32'(bus.ram_en), 32'h1);
            check($sformatf("tbl%0d_ram_addr", e), 32'(bus.ram_addr), 32'(ea));
            bus.req = '0;
            @(negedge clk);
        end

        // ---- Requester 2 writes 5/A5 then reads it back ----
        do_reset();
        set_req(2, 1'b1, 1'b1, 4'h5, 8'hA5);
        @(negedge clk);
        check("wr_gnt",      32'(bus.gnt), 32'h4);
        check("wr_ram_en",   32'(bus.ram_en), 32'h1);
        check("wr_ram_wr",   32'(bus.ram_wr_rd), 32'h1);
        check("wr_ram_addr", 32'(bus.ram_addr), 32'h5);
        check("wr_ram_din",  32'(bus.ram_din), 32'hA5);
        bus.req = '0;
        @(negedge clk);
        check("wr_done_busy", 32'(bus.busy), 32'h0);
        set_req(2, 1'b1, 1'b0, 4'h5, 8'h00);
        @(negedge clk);
        check("rd_gnt",    32'(bus.gnt), 32'h4);
        check("rd_ram_wr", 32'(bus.ram_wr_rd), 32'h0);
        bus.req = '0;
        @(negedge clk);
        check("rd_c2_rvalid", 32'(bus.rvalid), 32'h0);
        check("rd_c2_busy",   32'(bus.busy), 32'h1);
        @(negedge clk);
        check("rd_c3_rvalid", 32'(bus.rvalid), 32'h4);
        check("rd_c3_rdata",  32'(bus.rdata), 32'hA5);
        check("rd_c3_busy",   32'(bus.busy), 32'h0);
        @(negedge clk);
        check("rd_c4_rvalid", 32'(bus.rvalid), 32'h0);
        check("rd_hold_rdata", 32'(bus.rdata), 32'hA5);

        // ---- All four requesting continuously: order 0,1,2,3,0,1 ----
        do_reset();
        bus.req_wr_rd = '1;
        bus.req       = '1;
        got.delete();
        for (int t = 0; t < 40 && got.size() < 6; t++) begin
            @(negedge clk);
            for (int j = 0; j < N; j++) if (bus.gnt[j]) got.push_back(j);
            bus.req = ~bus.gnt;
        end
        bus.req = '0;
        check("rr4_grant_count", 32'(got.size()), 32'd6);
        for (int k = 0; k < got.size() && k < 6; k++)
            check($sformatf("rr4_order%0d", k), 32'(got[k]), 32'(k % 4));

        // ---- Requesters 1 and 3 read repeatedly ----
        do_reset();
        bus.req_wr_rd = '0;
        bus.req       = 4'b1010;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            eg = '0;
            er = '0;
            if (t % 3 == 1) eg = ((t / 3) % 2 == 0) ? 4'b0010 : 4'b1000;
            if (t % 3 == 0) er = (((t - 3) / 3) % 2 == 0) ? 4'b0010 : 4'b1000;
            check($sformatf("rd13_t%0d_gnt", t),    32'(bus.gnt), 32'(eg));
            check($sformatf("rd13_t%0d_rvalid", t), 32'(bus.rvalid), 32'(er));
            bus.req = 4'b1010 & ~bus.gnt;
        end
        bus.req = '0;

        // ---- Reset during RDATA of a read by requester 0 ----
        do_reset();
        set_req(0, 1'b1, 1'b0, 4'h5, 8'h00);
        @(negedge clk);
        check("rstrd_gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        @(negedge clk);
        check("rstrd_busy_rdata", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        for (int i = 1; i < N; i++) set_req(i, 1'b1, 1'b1, AW'(i), DW'(i));
        @(negedge clk);
        check("rstrd_rvalid", 32'(bus.rvalid), 32'h0);
        check("rstrd_busy",   32'(bus.busy), 32'h0);
        check("rstrd_gnt0",   32'(bus.gnt), 32'h0);
        check("rstrd_rdata",  32'(bus.rdata), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rstrd_after_gnt", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        @(negedge clk);
        check("rstrd_after_rvalid", 32'(bus.rvalid), 32'h0);

        // ---- Short request while busy is never served ----
        do_reset();
        set_req(3, 1'b1, 1'b0, 4'h2, 8'h00);
        @(negedge clk);
        check("short_gnt3",   32'(bus.gnt), 32'h8);
        check("short_ram_en", 32'(bus.ram_en), 32'h1);
        bus.req[3] = 1'b0;
        set_req(1, 1'b1, 1'b1, 4'h9, 8'h77);
        @(negedge clk);
        check("short_busy", 32'(bus.busy), 32'h1);
        bus.req[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("short_nognt%0d", k),  32'(bus.gnt), 32'h0);
            check($sformatf("short_noen%0d", k),   32'(bus.ram_en), 32'h0);
        end

        // ---- Randomized run against a transaction-level model ----
        ram_clear = 1'b1;
        do_reset();
        ram_clear = 1'b0;
        for (int i = 0; i < 16; i++) mem_ref[i] = '0;
        cyc       = 0;
        free_cyc  = 0;
        last_ref  = N - 1;
        gnt_at    = -1;
        g_idx     = 0;
        g_wr      = 1'b0;
        g_addr    = '0;
        g_din     = '0;
        rdata_exp = '0;
        rvq.delete();
        for (int it = 0; it < 3000; it++) begin
            for (int i = 0; i < N; i++) begin
                if (bus.gnt[i] || !bus.req[i]) begin
                    if ($urandom_range(99) < 35)
                        set_req(i, 1'b1, 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
                    else
                        bus.req[i] = 1'b0;
                end else if ($urandom_range(99) < 3) begin
                    bus.req[i] = 1'b0;
                end
            end
            // An access is accepted whenever the arbiter is free; the winner is
            // the first requester found after the previous winner.
            if (cyc >= free_cyc && bus.req != '0) begin
                g_idx = -1;
                for (int k = 1; k <= N; k++)
                    if (g_idx < 0 && bus.req[(last_ref + k) % N]) g_idx = (last_ref + k) % N;
                last_ref = g_idx;
                gnt_at   = cyc + 1;
                g_wr     = bus.req_wr_rd[g_idx];
                g_addr   = bus.req_addr[g_idx*AW +: AW];
                g_din    = bus.req_din[g_idx*DW +: DW];
                if (g_wr) begin
                    mem_ref[g_addr] = g_din;
                    free_cyc = cyc + 2;
                end else begin
                    rvq.push_back('{cyc + 3, g_idx, mem_ref[g_addr]});
                    free_cyc = cyc + 3;
                end
            end
            @(negedge clk);
            cyc++;
            eg = '0;
            er = '0;
            if (gnt_at == cyc) eg[g_idx] = 1'b1;
            if (rvq.size() > 0 && rvq[0].at == cyc) begin
                r = rvq.pop_front();
                er[r.idx] = 1'b1;
                rdata_exp = r.data;
            end
            check("rnd_gnt",    32'(bus.gnt), 32'(eg));
            check("rnd_rvalid", 32'(bus.rvalid), 32'(er));
            check("rnd_rdata",  32'(bus.rdata), 32'(rdata_exp));
            check("rnd_busy",   32'(bus.busy), 32'(cyc < free_cyc));
            check("rnd_ram_en", 32'(bus.ram_en), 32'(gnt_at == cyc));
            if (gnt_at == cyc) begin
                check("rnd_ram_wr",   32'(bus.ram_wr_rd), 32'(g_wr));
                check("rnd_ram_addr", 32'(bus.ram_addr), 32'(g_addr));
                if (g_wr) check("rnd_ram_din", 32'(bus.ram_din), 32'(g_din));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter that shares one single-port synchronous RAM (ports en, wr_rd, addr, din, dout) among NUM_REQ requesters. It latches one winning request, drives the RAM for exactly one cycle, and for reads returns the RAM output to the winner with a one-cycle valid pulse. It sits directly in front of the RAM. The RAM's own rst is driven elsewhere.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- ADDR_WIDTH, 4: RAM address width
- DATA_WIDTH, 8: RAM data width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester access request
- req_wr_rd  in  NUM_REQ  per-requester op: 1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address; slice i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_din  in  NUM_REQ*DATA_WIDTH  per-requester write data; same slicing rule
- gnt  out  NUM_REQ  one-hot grant pulse, registered
- rvalid  out  NUM_REQ  one-hot read-data-valid pulse, registered
- rdata  out  DATA_WIDTH  read data, shared by all requesters, qualified by rvalid
- busy  out  1  high whenever the state is not IDLE
- ram_en  out  1  RAM enable
- ram_wr_rd  out  1  RAM op, 1 = write
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_din  out  DATA_WIDTH  RAM write data
- ram_dout  in  DATA_WIDTH  RAM read data, valid one cycle after the read enable is sampled

## Operation
- FSM states: IDLE, ISSUE, RDATA.
- IDLE:
  - If req is nonzero, pick winner w by round-robin.
  - Latch w, req_wr_rd[w], and slices w of req_addr and req_din.
  - Update last to w and go to ISSUE.
  - If req is zero, stay in IDLE.
- Round-robin:
  - Search starts at (last+1) mod NUM_REQ and increments with wrap.
  - The first set req bit wins.
  - last resets to NUM_REQ-1, so requester 0 has top priority after reset.
- ISSUE (exactly one cycle):
  - ram_en=1; ram_wr_rd, ram_addr, ram_din come from the latch.
  - gnt[w]=1.
  - Next state is IDLE for a write, RDATA for a read.
- RDATA:
  - Register ram_dout into rdata.
  - Set rvalid[w]=1 for the following cycle.
  - Next state is IDLE.
- Requester protocol:
  - Hold req, op, addr and data stable until gnt is seen.
  - Drop req in the cycle after gnt unless another access is wanted; req still high in IDLE is a new request.
- A request withdrawn before arbitration is not served. Once latched, an access always completes, even if req drops.
- rdata holds its last value between rvalid pulses.
- ram_wr_rd, ram_addr and ram_din may hold stale values while ram_en=0.

## Timing
- Reset values: state=IDLE, last=NUM_REQ-1, gnt=0, rvalid=0, rdata=0, busy=0, ram_en=0, ram_wr_rd=0, ram_addr=0, ram_din=0.
- Write: req sampled at edge E0 → cycle after E0 has gnt and ram_en high → IDLE one cycle later. A write occupies 2 cycles.
- Read:
  - Cycle after E0: gnt and ram_en high.
  - Next cycle: RDATA, ram_dout valid.
  - Next cycle: rvalid[w]=1 with rdata, and the FSM is back in IDLE arbitrating.
  - req→rvalid is 3 cycles; a read occupies 3 cycles.
- gnt, rvalid and ram_en are each a single-cycle pulse. At most one bit of gnt|rvalid is set per cycle, except that rvalid of a finished read may coincide with nothing else.
- Requests arriving while busy=1 wait; they are evaluated in the next IDLE cycle.
- rst asserted in any state:
  - At the next edge, all outputs take their reset values.
  - A pending read produces no rvalid.
  - An ISSUE in progress during the rst cycle still presents ram_en that cycle; no new enable follows.

## Test plan
- Reset with all req=1 → first gnt=4'b0001 one cycle after rst drops; ram_en=1, and ram_addr equals requester 0's addr slice.
- Requester 2 writes addr 4'h5, data 8'hA5, then reads addr 4'h5 → ram_en/ram_wr_rd=1 pulse for the write. For the read, rvalid=4'b0100 with rdata=8'hA5 exactly 3 cycles after the read req is sampled.
- All four requesters hold req continuously, each dropping req after its gnt and reasserting next cycle → grant order 0,1,2,3,0,1; no requester granted twice before the others.
- Only requesters 1 and 3 request reads repeatedly → grants alternate 1,3,1,3; each read takes 3 cycles; rvalid one-hot matches the grantee.
- Assert rst during RDATA of a read by requester 0 → next cycle rvalid=0, busy=0, gnt=0. After release, the lowest-index requester wins.
- Requester 1 raises req for one cycle while busy=1 and drops it before IDLE → never granted; no ram_en pulse for it.
